// File: rtl/verificar_senha.sv
// rtl/verificar_senha.sv - PIN check lock controller with lockout and PIN change
package verificar_senha_pkg;
  typedef struct packed {
    logic       status;
    logic [3:0] digit4;
    logic [3:0] digit3;
    logic [3:0] digit2;
    logic [3:0] digit1;
  } pinPac_t;
endpackage

module verificar_senha
  import verificar_senha_pkg::*;
#(
  parameter logic [15:0] DEFAULT_PIN = 16'h1234,
  parameter int unsigned MAX_TRIES   = 3,
  parameter int unsigned T_OPEN      = 50_000_000,
  parameter int unsigned T_BLOCK     = 250_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  pinPac_t    pin_in,
  input  logic       change_req,
  output logic       door_unlock,
  output logic       blocked,
  output logic       ok_pulse,
  output logic       err_pulse,
  output logic [1:0] tries_left
);

  localparam logic [1:0] S_LOCKED  = 2'd0;
  localparam logic [1:0] S_OPEN    = 2'd1;
  localparam logic [1:0] S_NEWPIN  = 2'd2;
  localparam logic [1:0] S_BLOCKED = 2'd3;

  localparam logic [1:0]  TRIES_MAX  = 2'(MAX_TRIES);
  localparam logic [31:0] OPEN_LOAD  = 32'(T_OPEN - 1);
  localparam logic [31:0] BLOCK_LOAD = 32'(T_BLOCK - 1);

  logic [1:0]  state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [15:0] pin_q, pin_d;
  logic [1:0]  tries_q, tries_d;
  logic        door_q, door_d;
  logic        blocked_q, blocked_d;
  logic        ok_q, ok_d;
  logic        err_q, err_d;
  logic        status_prev_q;
  logic        chg_prev_q;

  logic        pin_event;
  logic        chg_edge;
  logic [15:0] pin_value;

  assign pin_event = pin_in.status & ~status_prev_q;
  assign chg_edge  = change_req & ~chg_prev_q;
  assign pin_value = {pin_in.digit4, pin_in.digit3, pin_in.digit2, pin_in.digit1};

  always_comb begin
    state_d = state_q;
    // Saturating countdown: the timer parks at zero outside timed states.
    timer_d = (timer_q != 32'd0) ? timer_q - 32'd1 : 32'd0;
    pin_d   = pin_q;
    tries_d = tries_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_LOCKED: begin
        if (pin_event) begin
          if (pin_value == pin_q) begin
            state_d = S_OPEN;
            ok_d    = 1'b1;
            tries_d = TRIES_MAX;
            timer_d = OPEN_LOAD;
          end else begin
            err_d = 1'b1;
            if (tries_q <= 2'd1) begin
              state_d = S_BLOCKED;
              tries_d = 2'd0;
              timer_d = BLOCK_LOAD;
            end else begin
              tries_d = tries_q - 2'd1;
            end
          end
        end
      end
      S_OPEN: begin
        if (timer_q == 32'd0) begin
          state_d = S_LOCKED;
        end else if (chg_edge) begin
          state_d = S_NEWPIN;
          timer_d = OPEN_LOAD;
        end
      end
      S_NEWPIN: begin
        // A send in the expiry cycle still counts; all-ones is never a valid PIN.
        if (pin_event) begin
          state_d = S_LOCKED;
          if (pin_value == 16'hFFFF) begin
            err_d = 1'b1;
          end else begin
            pin_d = pin_value;
            ok_d  = 1'b1;
          end
        end else if (timer_q == 32'd0) begin
          state_d = S_LOCKED;
          err_d   = 1'b1;
        end
      end
      S_BLOCKED: begin
        if (timer_q == 32'd0) begin
          state_d = S_LOCKED;
          tries_d = TRIES_MAX;
        end
      end
      default: state_d = S_LOCKED;
    endcase
    door_d    = (state_d == S_OPEN);
    blocked_d = (state_d == S_BLOCKED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_LOCKED;
      timer_q       <= 32'd0;
      pin_q         <= DEFAULT_PIN;
      tries_q       <= TRIES_MAX;
      door_q        <= 1'b0;
      blocked_q     <= 1'b0;
      ok_q          <= 1'b0;
      err_q         <= 1'b0;
      status_prev_q <= 1'b0;
      chg_prev_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      pin_q         <= pin_d;
      tries_q       <= tries_d;
      door_q        <= door_d;
      blocked_q     <= blocked_d;
      ok_q          <= ok_d;
      err_q         <= err_d;
      status_prev_q <= pin_in.status;
      chg_prev_q    <= change_req;
    end
  end

  assign door_unlock = door_q;
  assign blocked     = blocked_q;
  assign ok_pulse    = ok_q;
  assign err_pulse   = err_q;
  assign tries_left  = tries_q;

endmodule

// File: tb/tb_verificar_senha.sv
// tb/tb_verificar_senha.sv - scenario and randomized checks of verificar_senha
module tb_verificar_senha;
  import verificar_senha_pkg::*;

  localparam int T_OPEN    = 4;
  localparam int T_BLOCK   = 6;
  localparam int MAX_TRIES = 3;

  logic       clk = 1'b0;
  logic       rst;
  pinPac_t    pin_in;
  logic       change_req;
  logic       door_unlock, blocked, ok_pulse, err_pulse;
  logic [1:0] tries_left;

  int tests = 0;
  int fails = 0;

  verificar_senha #(.DEFAULT_PIN(16'h1234), .MAX_TRIES(MAX_TRIES), .T_OPEN(T_OPEN), .T_BLOCK(T_BLOCK)) dut (
    .clk(clk), .rst(rst), .pin_in(pin_in), .change_req(change_req),
    .door_unlock(door_unlock), .blocked(blocked), .ok_pulse(ok_pulse),
    .err_pulse(err_pulse), .tries_left(tries_left)
  );

  always #5 clk = ~clk;

  // Reference model: phases with a count of cycles still to run.
  localparam int M_LOCKED = 0, M_OPEN = 1, M_NEWPIN = 2, M_BLOCKED = 3;
  int          m_mode, m_left, m_tries;
  logic [15:0] m_pin;
  bit          m_prev_st, m_prev_chg, m_ok, m_err;

  task automatic model_reset();
    m_mode = M_LOCKED; m_left = 0; m_tries = MAX_TRIES; m_pin = 16'h1234;
    m_prev_st = 0; m_prev_chg = 0; m_ok = 0; m_err = 0;
  endtask

  task automatic model_step();
    bit ev, ce;
    logic [15:0] v;
    ev = pin_in.status && !m_prev_st;
    ce = change_req && !m_prev_chg;
    v  = {pin_in.digit4, pin_in.digit3, pin_in.digit2, pin_in.digit1};
    m_ok = 0; m_err = 0;
    case (m_mode)
      M_LOCKED: if (ev) begin
        if (v == m_pin) begin m_mode = M_OPEN; m_left = T_OPEN; m_ok = 1; m_tries = MAX_TRIES; end
        else begin
          m_err = 1; m_tries = m_tries - 1;
          if (m_tries == 0) begin m_mode = M_BLOCKED; m_left = T_BLOCK; end
        end
      end
      M_OPEN: begin
        m_left = m_left - 1;
        if (m_left == 0) m_mode = M_LOCKED;
        else if (ce) begin m_mode = M_NEWPIN; m_left = T_OPEN; end
      end
      M_NEWPIN: begin
        m_left = m_left - 1;
        if (ev) begin
          m_mode = M_LOCKED;
          if (v == 16'hFFFF) m_err = 1; else begin m_pin = v; m_ok = 1; end
        end else if (m_left == 0) begin m_mode = M_LOCKED; m_err = 1; end
      end
      default: begin
        m_left = m_left - 1;
        if (m_left == 0) begin m_mode = M_LOCKED; m_tries = MAX_TRIES; end
      end
    endcase
    m_prev_st = pin_in.status;
    m_prev_chg = change_req;
  endtask

  task automatic set_in(input bit st, input logic [15:0] v);
    pin_in = {st, v};
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; set_in(0, 16'h0000); change_req = 1'b0;
    @(posedge clk); #1;
    model_reset();
    rst = 1'b0;
  endtask

  task automatic send(input logic [15:0] v);
    set_in(1, v);
    tick();
    set_in(0, v);
  endtask

  task automatic open_and_request_change();
    send(16'h1234);
    tick();
    change_req = 1'b1;
    tick();
    change_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; change_req = 1'b0; set_in(1, 16'h1234);
    @(posedge clk); #1;
    tests++; if ({door_unlock, blocked, ok_pulse, err_pulse} !== 4'b0000) begin fails++; $display("FAIL reset_flags: got %b want 0000", {door_unlock, blocked, ok_pulse, err_pulse}); end
    tests++; if (tries_left !== 2'd3) begin fails++; $display("FAIL reset_tries: got %0d want 3", tries_left); end
    model_reset();
    rst = 1'b0;
    tick();
    tests++; if (ok_pulse !== 1'b1 || door_unlock !== 1'b1) begin fails++; $display("FAIL reset_first_edge_event: got ok=%b door=%b want 1 1", ok_pulse, door_unlock); end
    set_in(0, 16'h1234);
    repeat (6) tick();
  endtask

  task automatic test_correct_pin();
    int n_door, n_ok;
    do_reset();
    send(16'h1234);
    n_door = door_unlock; n_ok = ok_pulse;
    repeat (10) begin tick(); n_door += door_unlock; n_ok += ok_pulse; end
    tests++; if (n_door != T_OPEN) begin fails++; $display("FAIL open_cycles: got %0d want %0d", n_door, T_OPEN); end
    tests++; if (n_ok != 1) begin fails++; $display("FAIL open_ok_count: got %0d want 1", n_ok); end
    tests++; if (door_unlock !== 1'b0) begin fails++; $display("FAIL open_relock: got %b want 0", door_unlock); end
  endtask

  task automatic test_lockout();
    int n_blk, n_ok;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send(16'h0000);
      tests++; if (err_pulse !== 1'b1 || ok_pulse !== 1'b0) begin fails++; $display("FAIL lock_err%0d: got err=%b ok=%b want 1 0", i, err_pulse, ok_pulse); end
      tests++; if (tries_left !== 2'(2 - i)) begin fails++; $display("FAIL lock_tries%0d: got %0d want %0d", i, tries_left, 2 - i); end
      if (i < 2) begin
        tick();
        tests++; if (err_pulse !== 1'b0) begin fails++; $display("FAIL lock_err_width%0d: got %b want 0", i, err_pulse); end
      end
    end
    n_blk = blocked; n_ok = 0;
    for (int j = 0; j < 10; j++) begin
      if (j == 1) set_in(1, 16'h1234);
      if (j == 2) set_in(0, 16'h1234);
      tick();
      n_blk += blocked; n_ok += ok_pulse;
    end
    tests++; if (n_blk != T_BLOCK) begin fails++; $display("FAIL lock_blocked_cycles: got %0d want %0d", n_blk, T_BLOCK); end
    tests++; if (n_ok != 0 || door_unlock !== 1'b0) begin fails++; $display("FAIL lock_ignores_pin: got ok=%0d door=%b want 0 0", n_ok, door_unlock); end
    tests++; if (tries_left !== 2'd3) begin fails++; $display("FAIL lock_tries_restored: got %0d want 3", tries_left); end
  endtask

  task automatic test_repeated_send();
    do_reset();
    set_in(1, 16'h0000); tick();
    set_in(1, 16'h0001); tick();
    tests++; if (err_pulse !== 1'b0) begin fails++; $display("FAIL repeat_no_second_err: got %b want 0", err_pulse); end
    tick(); set_in(0, 16'h0000); tick();
    tests++; if (tries_left !== 2'd2) begin fails++; $display("FAIL repeat_tries: got %0d want 2", tries_left); end
  endtask

  task automatic test_pin_change();
    do_reset();
    open_and_request_change();
    tests++; if (door_unlock !== 1'b0) begin fails++; $display("FAIL change_door_closed: got %b want 0", door_unlock); end
    send(16'h5678);
    tests++; if (ok_pulse !== 1'b1 || err_pulse !== 1'b0) begin fails++; $display("FAIL change_store_ok: got ok=%b err=%b want 1 0", ok_pulse, err_pulse); end
    tick(); send(16'h1234);
    tests++; if (err_pulse !== 1'b1) begin fails++; $display("FAIL change_old_rejected: got %b want 1", err_pulse); end
    tick(); send(16'h5678);
    tests++; if (ok_pulse !== 1'b1 || door_unlock !== 1'b1) begin fails++; $display("FAIL change_new_opens: got ok=%b door=%b want 1 1", ok_pulse, door_unlock); end
    repeat (6) tick();
  endtask

  task automatic test_newpin_timeout();
    int err_at, n_ok;
    do_reset();
    open_and_request_change();
    err_at = -1; n_ok = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (err_pulse === 1'b1 && err_at < 0) err_at = i;
      n_ok += ok_pulse;
    end
    tests++; if (err_at != T_OPEN || n_ok != 0) begin fails++; $display("FAIL newpin_timeout: got err_at=%0d ok=%0d want %0d 0", err_at, n_ok, T_OPEN); end
    send(16'h1234);
    tests++; if (ok_pulse !== 1'b1) begin fails++; $display("FAIL newpin_timeout_oldpin: got %b want 1", ok_pulse); end
    repeat (6) tick();
  endtask

  task automatic test_newpin_event_at_expiry();
    do_reset();
    open_and_request_change();
    repeat (T_OPEN - 1) tick();
    send(16'h9ABC);
    tests++; if (ok_pulse !== 1'b1 || err_pulse !== 1'b0) begin fails++; $display("FAIL expiry_event_wins: got ok=%b err=%b want 1 0", ok_pulse, err_pulse); end
    tick(); send(16'h9ABC);
    tests++; if (door_unlock !== 1'b1) begin fails++; $display("FAIL expiry_new_pin_opens: got %b want 1", door_unlock); end
    repeat (6) tick();
  endtask

  task automatic test_change_at_expiry();
    int n_err;
    do_reset();
    send(16'h1234);
    repeat (T_OPEN - 1) tick();
    change_req = 1'b1;
    tick();
    n_err = 0;
    repeat (8) begin tick(); n_err += err_pulse; end
    change_req = 1'b0;
    tests++; if (door_unlock !== 1'b0 || n_err != 0) begin fails++; $display("FAIL change_at_expiry: got door=%b err=%0d want 0 0", door_unlock, n_err); end
  endtask

  task automatic test_newpin_ffff();
    do_reset();
    open_and_request_change();
    send(16'hFFFF);
    tests++; if (err_pulse !== 1'b1 || ok_pulse !== 1'b0) begin fails++; $display("FAIL ffff_rejected: got err=%b ok=%b want 1 0", err_pulse, ok_pulse); end
    tick(); send(16'h1234);
    tests++; if (ok_pulse !== 1'b1) begin fails++; $display("FAIL ffff_oldpin: got %b want 1", ok_pulse); end
    repeat (6) tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    open_and_request_change();
    send(16'h5678);
    for (int i = 0; i < 3; i++) begin tick(); send(16'h0000); end
    tick();
    tests++; if (blocked !== 1'b1) begin fails++; $display("FAIL midreset_pre_blocked: got %b want 1", blocked); end
    #2 rst = 1'b1;
    #1;
    tests++; if (blocked !== 1'b0 || tries_left !== 2'd3) begin fails++; $display("FAIL midreset_async: got blocked=%b tries=%0d want 0 3", blocked, tries_left); end
    @(posedge clk); #1;
    model_reset();
    rst = 1'b0;
    send(16'h1234);
    tests++; if (door_unlock !== 1'b1) begin fails++; $display("FAIL midreset_default_pin: got %b want 1", door_unlock); end
    repeat (6) tick();
  endtask

  task automatic test_random();
    logic [15:0] v;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      case ($urandom_range(0, 3))
        0: v = m_pin;
        1: v = 16'h1234;
        2: v = 16'hFFFF;
        default: v = 16'($urandom);
      endcase
      if ($urandom_range(0, 2) == 0) set_in(~pin_in.status, v);
      change_req = ($urandom_range(0, 3) == 0) ? ~change_req : change_req;
      tick();
      tests++;
      if (door_unlock !== (m_mode == M_OPEN) || blocked !== (m_mode == M_BLOCKED) ||
          ok_pulse !== m_ok || err_pulse !== m_err || tries_left !== 2'(m_tries)) begin
        fails++;
        $display("FAIL random_c%0d: got door=%b blk=%b ok=%b err=%b tries=%0d want %b %b %b %b %0d", c,
                 door_unlock, blocked, ok_pulse, err_pulse, tries_left,
                 m_mode == M_OPEN, m_mode == M_BLOCKED, m_ok, m_err, m_tries);
      end
    end
  endtask

  initial begin
    rst = 1'b1; change_req = 1'b0; set_in(0, 16'h0000);
    model_reset();
    test_reset();
    test_correct_pin();
    test_lockout();
    test_repeated_send();
    test_pin_change();
    test_newpin_timeout();
    test_newpin_event_at_expiry();
    test_change_at_expiry();
    test_newpin_ffff();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
